// File: rtl/vec_scale_pipe.sv
// vec_scale_pipe: N-lane signed fixed-point multiply (vec*scale >>> Q_BITS) with STAGES-deep valid/ready pipeline and bubble collapse.
// Define SATURATE_EN to clamp overflowing lanes and expose the per-lane out_ovf flags.
module vec_scale_pipe #(
   parameter int WIDTH  = 32,
   parameter int Q_BITS = 16,
   parameter int LANES  = 3,
   parameter int STAGES = 2,
   parameter int RND    = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_skip,
   input  logic [LANES*WIDTH-1:0]   in_vec,
   input  logic [LANES*WIDTH-1:0]   in_scale,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_skip,
   output logic [LANES*WIDTH-1:0]   out_vec,
   output logic                     busy
`ifdef SATURATE_EN
   ,
   output logic [LANES-1:0]         out_ovf
`endif
);
   localparam int PW = 2 * WIDTH;
   localparam logic signed [PW-1:0] HALF = RND != 0 ? PW'(1) << (Q_BITS - 1) : '0;

   logic [STAGES:0]          en;
   logic [STAGES-1:0]        v, sk, src_v, src_sk;
   logic [LANES*WIDTH-1:0]   d [STAGES];
   logic [LANES*WIDTH-1:0]   src_d [STAGES];
   logic [LANES*WIDTH-1:0]   prod;
   logic signed [PW-1:0]     p, r;
`ifdef SATURATE_EN
   logic [LANES-1:0]         ovf;
   logic [LANES-1:0]         o [STAGES];
   logic [LANES-1:0]         src_o [STAGES];
`endif

   // Full-width product so the shifted result can be range-checked before wrapping.
   always_comb begin
      prod = '0;
      p = '0;
      r = '0;
`ifdef SATURATE_EN
      ovf = '0;
`endif
      for (int i = 0; i < LANES; i++) begin
         p = $signed(in_vec[i*WIDTH +: WIDTH]) * $signed(in_scale[i*WIDTH +: WIDTH]) + HALF;
         r = p >>> Q_BITS;
`ifdef SATURATE_EN
         ovf[i] = !(&r[PW-1:WIDTH-1] || !(|r[PW-1:WIDTH-1]));
         prod[i*WIDTH +: WIDTH] = ovf[i] ? {r[PW-1], {(WIDTH-1){!r[PW-1]}}} : r[WIDTH-1:0];
`else
         prod[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
`endif
      end
   end

   // A stage may load when it is empty or its contents move on this cycle.
   always_comb begin
      en[STAGES] = out_ready;
      for (int s = STAGES - 1; s >= 0; s--) en[s] = !v[s] || en[s+1];
   end

   assign in_ready = en[0] && !rst;

   always_comb begin
      src_v  = STAGES'({v, in_valid && in_ready});
      src_sk = STAGES'({sk, in_skip});
      src_d[0] = prod;
      for (int s = 1; s < STAGES; s++) src_d[s] = d[s-1];
`ifdef SATURATE_EN
      src_o[0] = ovf;
      for (int s = 1; s < STAGES; s++) src_o[s] = o[s-1];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v  <= '0;
         sk <= '0;
         for (int s = 0; s < STAGES; s++) d[s] <= '0;
`ifdef SATURATE_EN
         for (int s = 0; s < STAGES; s++) o[s] <= '0;
`endif
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (en[s]) begin
               v[s]  <= src_v[s];
               sk[s] <= src_sk[s];
               d[s]  <= src_d[s];
`ifdef SATURATE_EN
               o[s]  <= src_o[s];
`endif
            end
         end
      end
   end

   assign out_valid = v[STAGES-1];
   assign out_skip  = sk[STAGES-1];
   assign out_vec   = d[STAGES-1];
   assign busy      = |v;
`ifdef SATURATE_EN
   assign out_ovf   = o[STAGES-1];
`endif
endmodule

// File: tb/tb_vec_scale_pipe.sv
// tb_vec_scale_pipe: table vectors, hand-written corner sequences and random traffic against a queue-based arithmetic model.
// Two instances (RND=0 and RND=1) share stimulus; SATURATE_EN switches expected overflow handling.
module tb_vec_scale_pipe;
   localparam int W  = 32;
   localparam int Q  = 16;
   localparam int L  = 3;
   localparam int S  = 2;
   localparam int VW = L * W;
`ifdef SATURATE_EN
   localparam logic [W-1:0] WRAP_P = 32'h7FFF_FFFF;
   localparam logic [W-1:0] WRAP_N = 32'h8000_0000;
`else
   localparam logic [W-1:0] WRAP_P = 32'hFFFE_0000;
   localparam logic [W-1:0] WRAP_N = 32'h0000_0000;
`endif

   logic clk = 0, rst = 1, in_valid = 0, in_skip = 0, out_ready = 1;
   logic [VW-1:0] in_vec = '0, in_scale = '0;
   logic in_ready, out_valid, out_skip, busy;
   logic in_ready_r, out_valid_r, out_skip_r, busy_r;
   logic [VW-1:0] out_vec, out_vec_r;
`ifdef SATURATE_EN
   logic [L-1:0] out_ovf, out_ovf_r;
`endif
   int tests = 0, fails = 0, emits = 0;

   always #5 clk = ~clk;

   vec_scale_pipe #(.WIDTH(W), .Q_BITS(Q), .LANES(L), .STAGES(S), .RND(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_skip(in_skip),
      .in_vec(in_vec), .in_scale(in_scale), .out_valid(out_valid), .out_ready(out_ready),
      .out_skip(out_skip), .out_vec(out_vec), .busy(busy)
`ifdef SATURATE_EN
      , .out_ovf(out_ovf)
`endif
   );

   vec_scale_pipe #(.WIDTH(W), .Q_BITS(Q), .LANES(L), .STAGES(S), .RND(1)) dut_r (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .in_skip(in_skip),
      .in_vec(in_vec), .in_scale(in_scale), .out_valid(out_valid_r), .out_ready(out_ready),
      .out_skip(out_skip_r), .out_vec(out_vec_r), .busy(busy_r)
`ifdef SATURATE_EN
      , .out_ovf(out_ovf_r)
`endif
   );

   typedef struct {
      logic [VW-1:0] vec, vec_r;
      logic          skip;
      logic [L-1:0]  ovf, ovf_r;
   } beat_t;

   typedef struct {
      logic [VW-1:0] a, b, e0, e1;
      logic          skip;
      logic [L-1:0]  ov;
   } vec_t;

   beat_t q[$];

   task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Real-valued rule: floor((a*b [+ half]) / 2^Q), then wrap or clamp to W signed bits.
   function automatic logic [W-1:0] lane_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input bit rnd, output logic ovf);
      longint lim, p;
      lim = longint'(1) << (W - 1);
      p = longint'($signed(a)) * longint'($signed(b));
      if (rnd) p += longint'(1) << (Q - 1);
      p = p >>> Q;
      ovf = (p >= lim) || (p < -lim);
`ifdef SATURATE_EN
      if (ovf) p = (p < 0) ? -lim : lim - 1;
`endif
      return p[W-1:0];
   endfunction

   function automatic beat_t model(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic skip);
      beat_t t;
      logic o;
      t.skip = skip;
      for (int i = 0; i < L; i++) begin
         t.vec[i*W +: W]   = lane_ref(a[i*W +: W], b[i*W +: W], 1'b0, o);
         t.ovf[i]          = o;
         t.vec_r[i*W +: W] = lane_ref(a[i*W +: W], b[i*W +: W], 1'b1, o);
         t.ovf_r[i]        = o;
      end
      return t;
   endfunction

   function automatic logic [VW-1:0] rv();
      logic [VW-1:0] x;
      logic [W-1:0] r;
      for (int i = 0; i < L; i++) begin
         r = $urandom;
         if ($urandom_range(0, 1) != 0) r = {{14{r[17]}}, r[17:0]};
         x[i*W +: W] = r;
      end
      return x;
   endfunction

   // Scoreboard: accepted beats are modelled on entry and matched in order on emission.
   logic stalled = 0;
   logic [VW-1:0] held;
   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         chk("rst_in_ready", {{(VW-1){1'b0}}, in_ready}, '0);
         q.delete();
         stalled = 0;
      end else begin
         if (stalled) begin
            chk("stall_valid", {{(VW-1){1'b0}}, out_valid}, 1);
            chk("stall_vec", out_vec, held);
         end
         if (out_valid && out_ready) begin
            emits++;
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL emit_unexpected: got beat %h, want no beat", out_vec);
            end else begin
               e = q.pop_front();
               chk("sb_vec", out_vec, e.vec);
               chk("sb_vec_rnd", out_vec_r, e.vec_r);
               chk("sb_valid_rnd", {{(VW-1){1'b0}}, out_valid_r}, 1);
               chk("sb_skip", {{(VW-1){1'b0}}, out_skip}, {{(VW-1){1'b0}}, e.skip});
`ifdef SATURATE_EN
               chk("sb_ovf", VW'(out_ovf), VW'(e.ovf));
               chk("sb_ovf_rnd", VW'(out_ovf_r), VW'(e.ovf_r));
`endif
            end
         end
         if (in_valid && in_ready) q.push_back(model(in_vec, in_scale, in_skip));
         stalled = out_valid && !out_ready;
         held = out_vec;
      end
   end

   task automatic wait_accept();
      logic acc;
      int n;
      acc = 0;
      n = 0;
      while (!acc) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (!acc) begin
            n++;
            if (n > 40) begin
               tests++;
               fails++;
               $display("FAIL accept_timeout: got no in_ready in %0d cycles, want accept", n);
               acc = 1;
            end
         end
      end
      in_valid = 0;
   endtask

   task automatic send(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic s);
      in_vec = a;
      in_scale = b;
      in_skip = s;
      in_valid = 1;
      wait_accept();
   endtask

   task automatic drain(input string name, input int want);
      in_valid = 0;
      out_ready = 1;
      repeat (S + 3) @(posedge clk);
      #1;
      chk(name, VW'(q.size()), 0);
      chk({name, "_count"}, VW'(emits), VW'(want));
   endtask

   vec_t tbl[4];
   int e0;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1);
   end

   initial begin
      tbl[0].a = {3{32'h0002_0000}};
      tbl[0].b = {3{32'h0001_8000}};
      tbl[0].e0 = {3{32'h0003_0000}};
      tbl[0].e1 = {3{32'h0003_0000}};
      tbl[0].skip = 1;
      tbl[0].ov = 3'b000;
      tbl[1].a = {32'h7FFF_0000, 32'h0000_0001, 32'hFFFF_0000};
      tbl[1].b = {32'h0002_0000, 32'h0000_8000, 32'h0000_8000};
      tbl[1].e0 = {WRAP_P, 32'h0000_0000, 32'hFFFF_8000};
      tbl[1].e1 = {WRAP_P, 32'h0000_0001, 32'hFFFF_8000};
      tbl[1].skip = 0;
      tbl[1].ov = 3'b100;
      tbl[2].a = {32'h8000_0000, 32'hFFFF_FFFF, 32'h0001_0000};
      tbl[2].b = {32'h0001_0000, 32'h0000_8000, 32'hFFFE_8000};
      tbl[2].e0 = {32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFE_8000};
      tbl[2].e1 = {32'h8000_0000, 32'h0000_0000, 32'hFFFE_8000};
      tbl[2].skip = 1;
      tbl[2].ov = 3'b000;
      tbl[3].a = {32'h0000_0003, 32'h7FFF_FFFF, 32'h8000_0000};
      tbl[3].b = {32'h0000_5555, 32'h0001_0000, 32'h0002_0000};
      tbl[3].e0 = {32'h0000_0000, 32'h7FFF_FFFF, WRAP_N};
      tbl[3].e1 = {32'h0000_0001, 32'h7FFF_FFFF, WRAP_N};
      tbl[3].skip = 0;
      tbl[3].ov = 3'b001;

      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", VW'(out_valid), 0);
      chk("reset_busy", VW'(busy), 0);
      chk("reset_in_ready", VW'(in_ready), 0);
`ifdef SATURATE_EN
      chk("reset_ovf", VW'(out_ovf), 0);
`endif
      rst = 0;
      @(posedge clk);
      #1;

      for (int t = 0; t < 4; t++) begin
         in_vec = tbl[t].a;
         in_scale = tbl[t].b;
         in_skip = tbl[t].skip;
         in_valid = 1;
         @(negedge clk);
         chk("tbl_ready", VW'(in_ready), 1);
         @(posedge clk);
         #1;
         in_valid = 0;
         for (int k = 1; k < S; k++) begin
            chk("tbl_early", VW'(out_valid), 0);
            @(posedge clk);
            #1;
         end
         chk("tbl_valid", VW'(out_valid), 1);
         chk("tbl_vec", out_vec, tbl[t].e0);
         chk("tbl_vec_rnd", out_vec_r, tbl[t].e1);
         chk("tbl_skip", VW'(out_skip), VW'(tbl[t].skip));
`ifdef SATURATE_EN
         chk("tbl_ovf", VW'(out_ovf), VW'(tbl[t].ov));
`endif
         @(posedge clk);
         #1;
      end

      e0 = emits;
      out_ready = 0;
      fork
         begin
            for (int k = 0; k < 6; k++) send(rv(), rv(), k[0]);
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            chk("bp_full_ready", VW'(in_ready), 0);
            chk("bp_full_busy", VW'(busy), 1);
            @(posedge clk);
            #1;
            out_ready = 1;
         end
      join
      drain("bp_drain", e0 + 6);

      e0 = emits;
      out_ready = 0;
      in_vec = rv();
      in_scale = rv();
      in_skip = 1;
      in_valid = 1;
      @(negedge clk);
      chk("bub_first_ready", VW'(in_ready), 1);
      @(posedge clk);
      #1;
      in_vec = rv();
      in_scale = rv();
      in_skip = 0;
      @(negedge clk);
      chk("bub_second_ready", VW'(in_ready), 1);
      @(posedge clk);
      #1;
      in_vec = rv();
      in_scale = rv();
      @(negedge clk);
      chk("bub_full_ready", VW'(in_ready), 0);
      @(posedge clk);
      #1;
      out_ready = 1;
      wait_accept();
      drain("bub_drain", e0 + 3);

      out_ready = 0;
      in_vec = rv();
      in_scale = rv();
      in_valid = 1;
      @(posedge clk);
      #1;
      in_vec = rv();
      @(posedge clk);
      #1;
      chk("mid_busy", VW'(busy), 1);
      chk("mid_valid", VW'(out_valid), 1);
      rst = 1;
      in_vec = rv();
      @(negedge clk);
      chk("mid_rst_ready", VW'(in_ready), 0);
      @(posedge clk);
      #1;
      rst = 0;
      in_valid = 0;
      chk("post_rst_valid", VW'(out_valid), 0);
      chk("post_rst_busy", VW'(busy), 0);
      e0 = emits;
      drain("post_rst_drain", e0);

      e0 = 0;
      for (int c = 0; c < 400; c++) begin
         logic acc;
         if (!in_valid && $urandom_range(0, 2) != 0) begin
            in_vec = rv();
            in_scale = rv();
            in_skip = 1'($urandom_range(0, 1));
            in_valid = 1;
         end
         out_ready = $urandom_range(0, 3) != 0;
         @(negedge clk);
         acc = in_valid && in_ready;
         if (acc) e0++;
         @(posedge clk);
         #1;
         if (acc) in_valid = 0;
      end
      e0 += emits - (emits - q.size());
      in_valid = 0;
      out_ready = 1;
      repeat (S + 3) @(posedge clk);
      #1;
      chk("rand_drain", VW'(q.size()), 0);
      chk("rand_idle", VW'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
